mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single owner of the byte-wide RAM/IO port; arbitrates between instruction fetch (32-bit words) and load/store buffer data requests.
- Splits each request into byte accesses and assembles read data little-endian.
- Throttles UART writes on io_buffer_full.
- Returns one-cycle completion pulses: if_done to fetch, lsb_done/lsb_pos_out to the load/store buffer.

Parameters:
- POS_W, 4, width of the load/store buffer slot tag carried with each data request.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global ready; low freezes all state
- clear  in  1  pipeline flush
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  write strobe (1 = write)
- if_req  in  1  fetch request (level); if_addr held stable until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle fetch completion pulse
- if_data  out  32  fetched word
- inst_need_work  out  1  fetch waiting for the port; buffer must not issue while high
- lsb_req  in  1  one-cycle data request pulse
- lsb_pos  in  POS_W  requester slot tag
- lsb_ls  in  1  0 = load, 1 = store
- lsb_len  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes
- lsb_addr  in  32  byte address
- lsb_val  in  32  store data
- mem_busy  out  1  data path cannot accept a request
- lsb_done  out  1  one-cycle data completion pulse
- lsb_pos_out  out  POS_W  tag of the completed request
- lsb_data  out  32  load data (raw, unused upper bytes 0); 0 for stores

Behaviour:
- Reset:
  - State IDLE; pending slot empty.
  - All outputs 0: mem_a, mem_dout, mem_wr, if_done, if_data, inst_need_work, mem_busy, lsb_done, lsb_pos_out, lsb_data.
- rdy_in low:
  - All registers hold.
  - mem_wr is forced 0.
- Pending slot:
  - lsb_req latches pos/ls/len/addr/val into the slot.
  - lsb_req while the slot is full is a protocol violation; the request is dropped.
- mem_busy:
  - = slot_valid OR data op active.
  - Derived only from registers; no combinational path from any input.
- inst_need_work = if_req AND fetch op not active.
- States: IDLE, FETCH, LOAD, STORE, IO_WAIT.
- IDLE:
  - Slot valid -> start data op; this clears the slot.
  - Otherwise if_req -> FETCH.
  - Data has fixed priority over fetch. inst_need_work gives fetch the next grant.
- Byte counter k, range 0..N, with N = 4 for fetch, otherwise 1 << len.
- Read (FETCH/LOAD):
  - Cycles 0..N-1: mem_a = addr + k, mem_wr = 0.
  - Cycles 1..N: capture mem_din into byte k-1.
  - The op occupies N+1 cycles. The done pulse is registered and visible in the cycle after the last capture; state returns to IDLE in that same cycle.
  - Fetch, 4 bytes: 5 cycles from first address to if_done.
  - Next op's first address is driven earliest in the cycle after the done pulse.
- STORE:
  - Cycles 0..N-1: mem_wr = 1, mem_a = addr + k, mem_dout = val[8k+7:8k].
  - lsb_done is visible the cycle after the last byte.
- IO addresses (addr[17:16] == 2'b11):
  - Store while io_buffer_full is high -> IO_WAIT: mem_wr = 0, k held.
  - io_buffer_full is rechecked before every byte.
  - Return to STORE on the first cycle io_buffer_full is low.
- Address arithmetic is 32-bit wrapping: 0xFFFFFFFF + 1 = 0.
- clear:
  - Empties the pending slot.
  - Aborts FETCH or LOAD immediately (IDLE next cycle, no done pulse).
  - A STORE or IO_WAIT in progress completes all remaining bytes. Its lsb_done is suppressed.
- Fetch abandoned (if_req low mid-FETCH): abort, no if_done.
- Simultaneous lsb_req and a completing op: the slot latches the request, and the new op starts from IDLE on the following cycle.
- if_done and lsb_done are never high in the same cycle.

Optional Feature:
- MEM_PERF_CNT_EN defined adds three 32-bit outputs, reset to 0, saturating at 0xFFFFFFFF:
  - perf_fetch_cyc: cycles spent in FETCH.
  - perf_data_cyc: cycles spent in LOAD or STORE.
  - perf_io_stall_cyc: cycles spent in IO_WAIT.
- Counters only increment while rdy_in is high.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Fetch only:
  - Stimulus: if_req, if_addr = 0x100, RAM[0x100..0x103] = 13 05 00 00.
  - Response: mem_a 0x100..0x103 on consecutive cycles; if_done pulse in cycle 5; if_data = 0x00000513.
- Load half:
  - Stimulus: lsb_req, pos = 3, len = 01, addr = 0x2002, RAM = 0xAB 0xCD.
  - Response: 3 cycles; lsb_done, lsb_pos_out = 3, lsb_data = 0x0000CDAB.
- Store word:
  - Stimulus: addr = 0x1000, val = 0xDEADBEEF.
  - Response: mem_wr = 1 for 4 cycles, bytes EF BE AD DE at 0x1000..0x1003; lsb_done one cycle later; mem_busy high from the cycle after lsb_req until the done cycle.
- UART store:
  - Stimulus: SB to 0x30000 with io_buffer_full held high 3 cycles.
  - Response: no mem_wr for 3 cycles; a single write of the byte when io_buffer_full falls.
- Contention:
  - Stimulus: if_req and lsb_req arrive together.
  - Response: data op first; inst_need_work high throughout; fetch starts the cycle after lsb_done.
- clear:
  - Clear during a LOAD (k = 1): no lsb_done, IDLE next cycle.
  - Clear during a 4-byte STORE (k = 1): remaining 3 bytes are written and lsb_done stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter between instruction fetch and load/store buffer requests.
// Define MEM_PERF_CNT_EN to add saturating FETCH / data / IO-stall cycle counters.
module mem_arbiter #(
  parameter int unsigned POS_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             io_buffer_full,
  input  logic [7:0]       mem_din,
  output logic [7:0]       mem_dout,
  output logic [31:0]      mem_a,
  output logic             mem_wr,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_done,
  output logic [31:0]      if_data,
  output logic             inst_need_work,
  input  logic             lsb_req,
  input  logic [POS_W-1:0] lsb_pos,
  input  logic             lsb_ls,
  input  logic [1:0]       lsb_len,
  input  logic [31:0]      lsb_addr,
  input  logic [31:0]      lsb_val,
  output logic             mem_busy,
  output logic             lsb_done,
  output logic [POS_W-1:0] lsb_pos_out,
  output logic [31:0]      lsb_data
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cyc,
  output logic [31:0]      perf_data_cyc,
  output logic [31:0]      perf_io_stall_cyc
`endif
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StStore, StIoWait} state_e;
  state_e state_q, state_d;

  logic             slot_valid_q, slot_valid_d, slot_load;
  logic [POS_W-1:0] slot_pos_q;
  logic             slot_ls_q;
  logic [1:0]       slot_len_q;
  logic [31:0]      slot_addr_q, slot_val_q;
  logic [2:0]       slot_n;

  logic [31:0]      op_addr_q, op_addr_d, op_val_q, op_val_d, op_buf_q, op_buf_d;
  logic [POS_W-1:0] op_pos_q, op_pos_d;
  logic [2:0]       op_n_q, op_n_d, k_q, k_d;
  logic             kill_q, kill_d;

  logic             if_done_d, lsb_done_d;
  logic [31:0]      if_data_d, lsb_data_d;
  logic [POS_W-1:0] lsb_pos_out_d;

  logic [31:0]      cur_addr, merged;
  logic [7:0]       store_byte;
  logic             is_io;

  assign cur_addr   = op_addr_q + {29'd0, k_q};
  assign is_io      = (cur_addr[17:16] == 2'b11);
  assign store_byte = op_val_q[{k_q[1:0], 3'b000} +: 8];
  assign slot_load  = lsb_req && !slot_valid_q && !clear;
  assign slot_n     = (slot_len_q == 2'b00) ? 3'd1 : (slot_len_q == 2'b01) ? 3'd2 : 3'd4;

  assign mem_busy       = slot_valid_q || (state_q == StLoad) || (state_q == StStore) ||
                          (state_q == StIoWait);
  assign inst_need_work = if_req && (state_q != StFetch);

  // Byte k-1 arrives one cycle after its address was driven.
  always_comb begin
    merged = op_buf_q;
    case (k_q)
      3'd1:    merged[7:0]   = mem_din;
      3'd2:    merged[15:8]  = mem_din;
      3'd3:    merged[23:16] = mem_din;
      3'd4:    merged[31:24] = mem_din;
      default: ;
    endcase
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    if (state_q == StIdle && slot_valid_q) slot_valid_d = 1'b0;
    if (slot_load) slot_valid_d = 1'b1;
    if (clear) slot_valid_d = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    op_addr_d     = op_addr_q;
    op_val_d      = op_val_q;
    op_buf_d      = op_buf_q;
    op_pos_d      = op_pos_q;
    op_n_d        = op_n_q;
    k_d           = k_q;
    kill_d        = kill_q;
    if_done_d     = 1'b0;
    lsb_done_d    = 1'b0;
    if_data_d     = if_data;
    lsb_data_d    = lsb_data;
    lsb_pos_out_d = lsb_pos_out;
    mem_a         = 32'd0;
    mem_dout      = 8'd0;
    mem_wr        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!clear) begin
          if (slot_valid_q) begin
            state_d   = slot_ls_q ? StStore : StLoad;
            op_addr_d = slot_addr_q;
            op_val_d  = slot_val_q;
            op_pos_d  = slot_pos_q;
            op_n_d    = slot_n;
            k_d       = 3'd0;
            op_buf_d  = 32'd0;
            kill_d    = 1'b0;
          // A request arriving this cycle lands in the slot and must win over fetch.
          end else if (if_req && !lsb_req) begin
            state_d   = StFetch;
            op_addr_d = if_addr;
            op_n_d    = 3'd4;
            k_d       = 3'd0;
            op_buf_d  = 32'd0;
          end
        end
      end
      StFetch, StLoad: begin
        if (k_q != op_n_q) mem_a = cur_addr;
        if (clear || (state_q == StFetch && !if_req)) begin
          state_d = StIdle;
        end else begin
          if (k_q != 3'd0) op_buf_d = merged;
          if (k_q == op_n_q) begin
            state_d = StIdle;
            if (state_q == StFetch) begin
              if_done_d = 1'b1;
              if_data_d = merged;
            end else begin
              lsb_done_d    = 1'b1;
              lsb_data_d    = merged;
              lsb_pos_out_d = op_pos_q;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      StStore: begin
        mem_a    = cur_addr;
        mem_dout = store_byte;
        if (clear) kill_d = 1'b1;
        if (is_io && io_buffer_full) begin
          state_d = StIoWait;
        end else begin
          mem_wr = rdy_in;
          if (k_q == op_n_q - 3'd1) begin
            state_d = StIdle;
            if (!kill_q && !clear) begin
              lsb_done_d    = 1'b1;
              lsb_data_d    = 32'd0;
              lsb_pos_out_d = op_pos_q;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      StIoWait: begin
        mem_a = cur_addr;
        if (clear) kill_d = 1'b1;
        if (!io_buffer_full) state_d = StStore;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      slot_valid_q <= 1'b0;
      slot_pos_q   <= '0;
      slot_ls_q    <= 1'b0;
      slot_len_q   <= 2'd0;
      slot_addr_q  <= 32'd0;
      slot_val_q   <= 32'd0;
      op_addr_q    <= 32'd0;
      op_val_q     <= 32'd0;
      op_buf_q     <= 32'd0;
      op_pos_q     <= '0;
      op_n_q       <= 3'd0;
      k_q          <= 3'd0;
      kill_q       <= 1'b0;
      if_done      <= 1'b0;
      if_data      <= 32'd0;
      lsb_done     <= 1'b0;
      lsb_data     <= 32'd0;
      lsb_pos_out  <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      if (slot_load) begin
        slot_pos_q  <= lsb_pos;
        slot_ls_q   <= lsb_ls;
        slot_len_q  <= lsb_len;
        slot_addr_q <= lsb_addr;
        slot_val_q  <= lsb_val;
      end
      op_addr_q    <= op_addr_d;
      op_val_q     <= op_val_d;
      op_buf_q     <= op_buf_d;
      op_pos_q     <= op_pos_d;
      op_n_q       <= op_n_d;
      k_q          <= k_d;
      kill_q       <= kill_d;
      if_done      <= if_done_d;
      if_data      <= if_data_d;
      lsb_done     <= lsb_done_d;
      lsb_data     <= lsb_data_d;
      lsb_pos_out  <= lsb_pos_out_d;
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_fetch_cyc    <= 32'd0;
      perf_data_cyc     <= 32'd0;
      perf_io_stall_cyc <= 32'd0;
    end else if (rdy_in) begin
      if (state_q == StFetch && perf_fetch_cyc != 32'hFFFF_FFFF)
        perf_fetch_cyc <= perf_fetch_cyc + 32'd1;
      if ((state_q == StLoad || state_q == StStore) && perf_data_cyc != 32'hFFFF_FFFF)
        perf_data_cyc <= perf_data_cyc + 32'd1;
      if (state_q == StIoWait && perf_io_stall_cyc != 32'hFFFF_FFFF)
        perf_io_stall_cyc <= perf_io_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps with a scoreboard of expected fetch words,
// load/store completions and RAM writes; a synchronous RAM model answers reads.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned POS_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear, io_buffer_full;
  logic [7:0]       mem_din, mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic             if_req, if_done, inst_need_work;
  logic [31:0]      if_addr, if_data;
  logic             lsb_req, lsb_ls, mem_busy, lsb_done;
  logic [POS_W-1:0] lsb_pos, lsb_pos_out;
  logic [1:0]       lsb_len;
  logic [31:0]      lsb_addr, lsb_val, lsb_data;

  mem_arbiter #(.POS_W(POS_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data), .inst_need_work(inst_need_work),
    .lsb_req(lsb_req), .lsb_pos(lsb_pos), .lsb_ls(lsb_ls), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_val(lsb_val), .mem_busy(mem_busy), .lsb_done(lsb_done),
    .lsb_pos_out(lsb_pos_out), .lsb_data(lsb_data)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed { logic [POS_W-1:0] pos; logic [31:0] data; } lsb_exp_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] data; } wr_exp_t;

  logic [31:0] exp_if_q[$];
  lsb_exp_t    exp_lsb_q[$];
  wr_exp_t     exp_wr_q[$];
  lsb_exp_t    mon_l;
  wr_exp_t     mon_w;
  int          errors = 0;
  int          checks = 0;

  logic [7:0]  ram [0:262143];
  logic [31:0] a_s;
  logic        wr_s;
  logic [7:0]  d_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic px();
    @(posedge clk_in);
    #1;
  endtask

  task automatic nx();
    @(negedge clk_in);
  endtask

  // Port sampled mid-cycle; data returns on mem_din one cycle after its address.
  always @(negedge clk_in) begin
    a_s  <= mem_a;
    wr_s <= mem_wr;
    d_s  <= mem_dout;
  end

  always @(posedge clk_in) begin
    mem_din <= ram[a_s[17:0]];
    if (wr_s === 1'b1) ram[a_s[17:0]] <= d_s;
  end

  always @(negedge clk_in) begin
    if (rst_in === 1'b0) begin
      check("done_exclusive", {31'd0, if_done & lsb_done}, 32'd0);
      if (if_done) begin
        check("if_done_expected", {31'd0, exp_if_q.size() != 0}, 32'd1);
        if (exp_if_q.size() != 0) check("sb_if_data", if_data, exp_if_q.pop_front());
      end
      if (lsb_done) begin
        check("lsb_done_expected", {31'd0, exp_lsb_q.size() != 0}, 32'd1);
        if (exp_lsb_q.size() != 0) begin
          mon_l = exp_lsb_q.pop_front();
          check("sb_lsb_pos", {28'd0, lsb_pos_out}, {28'd0, mon_l.pos});
          check("sb_lsb_data", lsb_data, mon_l.data);
        end
      end
      if (mem_wr) begin
        check("wr_expected", {31'd0, exp_wr_q.size() != 0}, 32'd1);
        if (exp_wr_q.size() != 0) begin
          mon_w = exp_wr_q.pop_front();
          check("sb_wr_addr", mem_a, mon_w.addr);
          check("sb_wr_data", {24'd0, mem_dout}, {24'd0, mon_w.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    lsb_req = 1'b0; lsb_pos = '0; lsb_ls = 1'b0; lsb_len = 2'd0; lsb_addr = 32'd0;
    lsb_val = 32'd0; wr_s = 1'b0; a_s = 32'd0; d_s = 8'd0;
    for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
    #1;
    ram[18'h00100] <= 8'h13; ram[18'h00101] <= 8'h05;
    ram[18'h00102] <= 8'h00; ram[18'h00103] <= 8'h00;
    ram[18'h02002] <= 8'hAB; ram[18'h02003] <= 8'hCD;
    ram[18'h00200] <= 8'h11; ram[18'h00201] <= 8'h22;
    ram[18'h00202] <= 8'h33; ram[18'h00203] <= 8'h44;
    ram[18'h3FFFF] <= 8'h5C; ram[18'h00000] <= 8'h7E;

    repeat (3) px();
    nx();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_flags", {26'd0, mem_wr, if_done, lsb_done, mem_busy, inst_need_work, 1'b0},
          32'd0);
    check("rst_data", if_data | lsb_data | {24'd0, mem_dout} | {28'd0, lsb_pos_out}, 32'd0);
    px(); rst_in = 1'b0; nx();
    check("idle_busy", {31'd0, mem_busy}, 32'd0);

    // Fetch 0x100: four addresses then if_done five cycles after the first.
    px(); if_req = 1'b1; if_addr = 32'h100; exp_if_q.push_back(32'h0000_0513); nx();
    check("fetch_need_work", {31'd0, inst_need_work}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      px(); nx();
      check("fetch_addr", mem_a, 32'h100 + i);
      check("fetch_no_wr", {31'd0, mem_wr}, 32'd0);
    end
    px(); nx();
    check("fetch_not_done_early", {31'd0, if_done}, 32'd0);
    px(); if_req = 1'b0; nx();
    check("fetch_done", {31'd0, if_done}, 32'd1);
    check("fetch_data", if_data, 32'h0000_0513);

    // Load halfword from 0x2002, tag 3.
    px(); lsb_req = 1'b1; lsb_pos = 4'd3; lsb_ls = 1'b0; lsb_len = 2'b01;
    lsb_addr = 32'h2002; exp_lsb_q.push_back('{pos: 4'd3, data: 32'h0000_CDAB}); nx();
    px(); lsb_req = 1'b0; nx();
    check("load_busy_slot", {31'd0, mem_busy}, 32'd1);
    px(); nx(); check("load_addr0", mem_a, 32'h2002);
    px(); nx(); check("load_addr1", mem_a, 32'h2003);
    px(); nx(); check("load_not_done_early", {31'd0, lsb_done}, 32'd0);
    px(); nx();
    check("load_done", {31'd0, lsb_done}, 32'd1);
    check("load_data", lsb_data, 32'h0000_CDAB);

    // Store word 0xDEADBEEF to 0x1000.
    px(); lsb_req = 1'b1; lsb_pos = 4'd5; lsb_ls = 1'b1; lsb_len = 2'b10;
    lsb_addr = 32'h1000; lsb_val = 32'hDEAD_BEEF;
    exp_wr_q.push_back('{addr: 32'h1000, data: 8'hEF});
    exp_wr_q.push_back('{addr: 32'h1001, data: 8'hBE});
    exp_wr_q.push_back('{addr: 32'h1002, data: 8'hAD});
    exp_wr_q.push_back('{addr: 32'h1003, data: 8'hDE});
    exp_lsb_q.push_back('{pos: 4'd5, data: 32'd0}); nx();
    px(); lsb_req = 1'b0; nx();
    check("store_busy_slot", {31'd0, mem_busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      px(); nx();
      check("store_wr", {31'd0, mem_wr}, 32'd1);
      check("store_busy", {31'd0, mem_busy}, 32'd1);
    end
    px(); nx();
    check("store_done", {31'd0, lsb_done}, 32'd1);
    check("store_wr_off", {31'd0, mem_wr}, 32'd0);

    // UART byte store held off by io_buffer_full.
    px(); lsb_req = 1'b1; lsb_pos = 4'd2; lsb_ls = 1'b1; lsb_len = 2'b00;
    lsb_addr = 32'h0003_0000; lsb_val = 32'h41; io_buffer_full = 1'b1;
    exp_wr_q.push_back('{addr: 32'h0003_0000, data: 8'h41});
    exp_lsb_q.push_back('{pos: 4'd2, data: 32'd0}); nx();
    px(); lsb_req = 1'b0; nx();
    for (int i = 0; i < 3; i++) begin
      px(); nx();
      check("uart_held", {31'd0, mem_wr}, 32'd0);
    end
    px(); io_buffer_full = 1'b0; nx();
    check("uart_resume_wait", {31'd0, mem_wr}, 32'd0);
    px(); nx(); check("uart_write", {31'd0, mem_wr}, 32'd1);
    px(); nx(); check("uart_done", {31'd0, lsb_done}, 32'd1);

    // Contention: data first, fetch the cycle after lsb_done.
    px(); if_req = 1'b1; if_addr = 32'h200; lsb_req = 1'b1; lsb_pos = 4'd7; lsb_ls = 1'b0;
    lsb_len = 2'b00; lsb_addr = 32'h2002;
    exp_lsb_q.push_back('{pos: 4'd7, data: 32'h0000_00AB});
    exp_if_q.push_back(32'h4433_2211); nx();
    check("cont_need_work", {31'd0, inst_need_work}, 32'd1);
    px(); lsb_req = 1'b0; nx();
    check("cont_need_work", {31'd0, inst_need_work}, 32'd1);
    px(); nx(); check("cont_load_addr", mem_a, 32'h2002);
    check("cont_need_work", {31'd0, inst_need_work}, 32'd1);
    px(); nx(); check("cont_need_work", {31'd0, inst_need_work}, 32'd1);
    px(); nx();
    check("cont_lsb_done", {31'd0, lsb_done}, 32'd1);
    check("cont_need_work", {31'd0, inst_need_work}, 32'd1);
    px(); nx();
    check("cont_fetch_addr", mem_a, 32'h200);
    check("cont_fetch_active", {31'd0, inst_need_work}, 32'd0);
    repeat (4) begin px(); nx(); end
    px(); if_req = 1'b0; nx();
    check("cont_if_done", {31'd0, if_done}, 32'd1);

    // Clear during a 4-byte load at k=1.
    px(); lsb_req = 1'b1; lsb_pos = 4'd1; lsb_ls = 1'b0; lsb_len = 2'b10;
    lsb_addr = 32'h2000; nx();
    px(); lsb_req = 1'b0; nx();
    px(); nx();
    px(); clear = 1'b1; nx(); check("clr_load_addr1", mem_a, 32'h2001);
    px(); clear = 1'b0; nx();
    check("clr_load_idle_a", mem_a, 32'd0);
    check("clr_load_idle_busy", {31'd0, mem_busy}, 32'd0);
    repeat (4) begin px(); nx(); check("clr_load_no_done", {31'd0, lsb_done}, 32'd0); end

    // Clear during a 4-byte store at k=1: all bytes still written, no lsb_done.
    px(); lsb_req = 1'b1; lsb_pos = 4'd4; lsb_ls = 1'b1; lsb_len = 2'b10;
    lsb_addr = 32'h1100; lsb_val = 32'h1122_3344;
    exp_wr_q.push_back('{addr: 32'h1100, data: 8'h44});
    exp_wr_q.push_back('{addr: 32'h1101, data: 8'h33});
    exp_wr_q.push_back('{addr: 32'h1102, data: 8'h22});
    exp_wr_q.push_back('{addr: 32'h1103, data: 8'h11}); nx();
    px(); lsb_req = 1'b0; nx();
    px(); nx();
    px(); clear = 1'b1; nx();
    px(); clear = 1'b0; nx(); check("clr_store_k2_wr", {31'd0, mem_wr}, 32'd1);
    px(); nx(); check("clr_store_k3_wr", {31'd0, mem_wr}, 32'd1);
    repeat (3) begin px(); nx(); check("clr_store_no_done", {31'd0, lsb_done}, 32'd0); end
    check("clr_store_all_bytes", exp_wr_q.size(), 32'd0);

    // rdy_in low freezes the store and masks mem_wr.
    px(); lsb_req = 1'b1; lsb_pos = 4'd6; lsb_ls = 1'b1; lsb_len = 2'b00;
    lsb_addr = 32'h1200; lsb_val = 32'h5A;
    exp_wr_q.push_back('{addr: 32'h1200, data: 8'h5A});
    exp_lsb_q.push_back('{pos: 4'd6, data: 32'd0}); nx();
    px(); lsb_req = 1'b0; nx();
    repeat (2) begin
      px(); rdy_in = 1'b0; nx();
      check("rdy_low_no_wr", {31'd0, mem_wr}, 32'd0);
      check("rdy_low_addr_hold", mem_a, 32'h1200);
    end
    px(); rdy_in = 1'b1; nx(); check("rdy_high_wr", {31'd0, mem_wr}, 32'd1);
    px(); nx(); check("rdy_store_done", {31'd0, lsb_done}, 32'd1);

    // Address wrap: halfword at 0xFFFFFFFF reads bytes at 0xFFFFFFFF and 0x0.
    px(); lsb_req = 1'b1; lsb_pos = 4'd9; lsb_ls = 1'b0; lsb_len = 2'b01;
    lsb_addr = 32'hFFFF_FFFF; exp_lsb_q.push_back('{pos: 4'd9, data: 32'h0000_7E5C}); nx();
    px(); lsb_req = 1'b0; nx();
    px(); nx(); check("wrap_addr0", mem_a, 32'hFFFF_FFFF);
    px(); nx(); check("wrap_addr1", mem_a, 32'h0);
    px(); nx();
    px(); nx(); check("wrap_done", {31'd0, lsb_done}, 32'd1);

    // Fetch abandoned mid-flight: no if_done.
    px(); if_req = 1'b1; if_addr = 32'h300; nx();
    px(); nx(); check("abandon_addr0", mem_a, 32'h300);
    px(); if_req = 1'b0; nx();
    repeat (5) begin px(); nx(); check("abandon_no_done", {31'd0, if_done}, 32'd0); end

    check("sb_if_drained", exp_if_q.size(), 32'd0);
    check("sb_lsb_drained", exp_lsb_q.size(), 32'd0);
    check("sb_wr_drained", exp_wr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
